mem_trace_buf: RTL and testbench
================================

Name: mem_trace_buf

Overview:
Parametrised non-intrusive bus-trace buffer that snoops a CPU data port and records accepted writes and completed reads into an on-chip circular buffer. Each entry holds address, data, flags and, optionally, a timestamp. Adds over the previous tracer: configurable width and depth, an address filter, wrap/stop-on-full modes, drop accounting, and oldest-relative readout over a request/ack/resp port. Sits beside the tile data bus; the debug side reads it through the tile's slave address map.

Parameters:
DATA_W, 32, monitored data width (≤32)
ADDR_W, 32, monitored address width (≤32)
DEPTH, 256, number of entries; power of two, ≥4
TS_W, 16, timestamp counter width (≤32)

Ports:
clk  in  1  clock
rst  in  1  reset
ctrl_en_i  in  1  capture enable
ctrl_flush_i  in  1  flush request, single-cycle pulse
ctrl_mode_i  in  1  0 = wrap (overwrite oldest), 1 = stop when full
filt_base_i  in  ADDR_W  filter base address
filt_mask_i  in  ADDR_W  filter mask; all-zero = record everything
mon_req_i, mon_ack_i, mon_we_i  in  1 each  monitored handshake
mon_addr_i  in  ADDR_W  monitored address
mon_wdata_i  in  DATA_W  monitored write data
mon_resp_i  in  1  monitored read-data valid
mon_rdata_i  in  DATA_W  monitored read data
rd_req_i  in  1  readout request
rd_idx_i  in  $clog2(DEPTH)  entry index, 0 = oldest
rd_field_i  in  2  0 addr, 1 data, 2 flags, 3 timestamp
rd_ack_o  out  1  readout accepted
rd_resp_o  out  1  readout data valid
rd_data_o  out  32  readout data, zero-extended
count_o  out  $clog2(DEPTH)+1  valid entries
overflow_o  out  1  sticky: buffer reached full
drop_cnt_o  out  16  saturating count of dropped events
flush_done_o  out  1  one-cycle pulse at end of flush
busy_o  out  1  flush in progress

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk. All outputs reset to 0; internal pointers, count, skid register, pending-read flag, timestamp and FSM state (IDLE) are cleared.
- Event sources:
  - Write event: mon_req_i & mon_ack_i & mon_we_i.
  - Read accept: mon_req_i & mon_ack_i & ~mon_we_i. Latches the address and sets pending.
  - Read event: mon_resp_i & pending. Uses the latched address and mon_rdata_i, then clears pending.
  - Only one read is outstanding at a time. A new read accept in the same cycle as mon_resp_i re-latches the address.
- Recording conditions: an event is recorded only when ctrl_en_i=1, FSM is IDLE, and (addr & filt_mask_i) == (filt_base_i & filt_mask_i).
- Storage: one entry is written per cycle.
  - If a read event and a write event occur together, the read event is written and the write event goes to a 1-entry skid register; the skid drains next cycle ahead of any new event.
  - If an event arrives while the skid is occupied and another write is also taken that cycle, the arriving event is dropped and drop_cnt_o increments, saturating at 16'hFFFF.
- Flags field: bit0 = write, bit1 = read, bit2 = event came via skid.
- Full handling (count_o == DEPTH):
  - Wrap mode: the oldest entry is overwritten, head advances by 1, count stays at DEPTH.
  - Stop mode: the event is dropped and drop_cnt_o increments.
  - In both modes overflow_o sets on the first full condition and is cleared only by flush or reset.
- Pointers: wr_ptr and head are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Readout port:
  - rd_ack_o = ~busy_o; storage has a dedicated read port, so capture never blocks reads.
  - Latency is 1: for an accepted request, rd_resp_o=1 and rd_data_o are valid on the next cycle.
  - Physical index = (head + rd_idx_i) mod DEPTH.
  - If rd_idx_i ≥ count_o, the response is all-zero.
- Flush FSM:
  - IDLE: on ctrl_flush_i go to FLUSH.
  - FLUSH: clear one entry per cycle for DEPTH cycles; busy_o=1; capture and reads are ignored; pending and skid are discarded.
  - On the last entry go to DONE.
  - DONE: flush_done_o=1 for one cycle, count/head/wr_ptr/overflow/drop_cnt are zero, then return to IDLE.
  - ctrl_flush_i during FLUSH is ignored.
- Timestamp: free-running TS_W counter, wraps, cleared by reset and flush. The sampled value is the cycle the event occurred; a skidded write keeps its original stamp.
- ctrl_en_i falling while a read is pending: the completion is still tracked but not recorded.

Optional Feature:
MEM_TRACE_TS_EN
- Defined: the timestamp counter and per-entry TS_W storage exist; field 3 returns the stamp.
- Undefined: no timestamp logic or storage; field 3 reads 0.

Test Plan:
- Reset, en=1, mask=0, writes to 0x100/0x104 with data 0xA5/0x5A -> count_o=2; idx0 field0=0x100, field1=0xA5, field2=0x1.
- Read of 0x200 accepted, mon_resp_i two cycles later with 0xDEAD -> one entry: addr 0x200, data 0xDEAD, flags 0x2.
- Wrap mode, DEPTH+3 writes with addresses 0..DEPTH+2 -> count_o=DEPTH, overflow_o=1, idx0 addr=3; stop mode same stimulus -> idx0 addr=0, drop_cnt_o=3.
- filt_base=0x1000, mask=0xF000; writes to 0x1004 and 0x2004 -> only 0x1004 recorded.
- Read completion coincident with a write, then back-to-back writes -> both recorded, write has flags bit2=1; an event arriving while the skid is held and another write is taken -> drop_cnt_o=1.
- Flush pulse with 5 entries stored -> busy_o high for DEPTH cycles, flush_done_o pulse, count_o=0, rd_ack_o low during flush; assert rst mid-flush -> FSM IDLE, busy_o=0 immediately.

Source files
------------

// File: rtl/mem_trace_buf_if.sv
// Snooped CPU data-port signals plus the debug readout request/ack/resp port of mem_trace_buf.
interface mem_trace_buf_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
);
    localparam int IDX_W = $clog2(DEPTH);

    logic              mon_req_i;
    logic              mon_ack_i;
    logic              mon_we_i;
    logic [ADDR_W-1:0] mon_addr_i;
    logic [DATA_W-1:0] mon_wdata_i;
    logic              mon_resp_i;
    logic [DATA_W-1:0] mon_rdata_i;
    logic              rd_req_i;
    logic [IDX_W-1:0]  rd_idx_i;
    logic [1:0]        rd_field_i;
    logic              rd_ack_o;
    logic              rd_resp_o;
    logic [31:0]       rd_data_o;

    modport master (
        output mon_req_i, mon_ack_i, mon_we_i, mon_addr_i, mon_wdata_i,
        output mon_resp_i, mon_rdata_i,
        output rd_req_i, rd_idx_i, rd_field_i,
        input  rd_ack_o, rd_resp_o, rd_data_o
    );

    modport slave (
        input  mon_req_i, mon_ack_i, mon_we_i, mon_addr_i, mon_wdata_i,
        input  mon_resp_i, mon_rdata_i,
        input  rd_req_i, rd_idx_i, rd_field_i,
        output rd_ack_o, rd_resp_o, rd_data_o
    );
endinterface

// File: rtl/mem_trace_buf.sv
// Non-intrusive bus tracer: records accepted writes and completed reads into a circular buffer.
// Define MEM_TRACE_TS_EN to add a per-entry timestamp (readout field 3); otherwise field 3 reads 0.
module mem_trace_buf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256,
    parameter int TS_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ctrl_en_i,
    input  logic                   ctrl_flush_i,
    input  logic                   ctrl_mode_i,
    input  logic [ADDR_W-1:0]      filt_base_i,
    input  logic [ADDR_W-1:0]      filt_mask_i,
    mem_trace_buf_if.slave         bus,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o,
    output logic [15:0]            drop_cnt_o,
    output logic                   flush_done_o,
    output logic                   busy_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]        state;
    logic [IDX_W-1:0]  flush_idx;
    logic [IDX_W-1:0]  head;
    logic [IDX_W-1:0]  wr_ptr;
    logic [IDX_W-1:0]  rd_phys;
    logic              pending;
    logic [ADDR_W-1:0] lat_addr;
    logic              skid_valid;
    logic [ADDR_W-1:0] skid_addr;
    logic [DATA_W-1:0] skid_data;

    logic [ADDR_W-1:0] mem_addr  [DEPTH];
    logic [DATA_W-1:0] mem_data  [DEPTH];
    logic [2:0]        mem_flags [DEPTH];

    logic              flush_start;
    logic              clearing;
    logic              idle_run;
    logic              cap_ok;
    logic              full;
    logic              rd_accept;
    logic              wr_hit;
    logic              rd_hit;
    logic              wr_ev;
    logic              rd_ev;
    logic              st_valid;
    logic              st_drop;
    logic              st_we;
    logic              skid_load;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic [2:0]        st_flags;
    logic [1:0]        drop_inc;
    logic [16:0]       drop_sum;
    logic [TS_W-1:0]   ts_rd;
    logic              rd_take;

    assign flush_start = (state == S_IDLE) && ctrl_flush_i;
    assign clearing    = flush_start || (state == S_FLUSH);
    assign idle_run    = (state == S_IDLE) && !ctrl_flush_i;
    assign cap_ok      = idle_run && ctrl_en_i;
    assign full        = (count_o == FULL_CNT);

    // Filter compares only the address bits selected by the mask; an all-zero mask matches everything.
    assign wr_hit    = ((bus.mon_addr_i ^ filt_base_i) & filt_mask_i) == '0;
    assign rd_hit    = ((lat_addr ^ filt_base_i) & filt_mask_i) == '0;
    assign rd_accept = bus.mon_req_i && bus.mon_ack_i && !bus.mon_we_i;
    assign wr_ev     = bus.mon_req_i && bus.mon_ack_i && bus.mon_we_i && cap_ok && wr_hit;
    assign rd_ev     = bus.mon_resp_i && pending && cap_ok && rd_hit;

    // One store per cycle: a held skid entry goes first and anything arriving alongside it is lost.
    always_comb begin
        st_valid  = 1'b0;
        st_addr   = '0;
        st_data   = '0;
        st_flags  = 3'b000;
        skid_load = 1'b0;
        drop_inc  = 2'd0;
        if (idle_run && skid_valid) begin
            st_valid = 1'b1;
            st_addr  = skid_addr;
            st_data  = skid_data;
            st_flags = 3'b101;
            drop_inc = {1'b0, rd_ev} + {1'b0, wr_ev};
        end else if (rd_ev) begin
            st_valid  = 1'b1;
            st_addr   = lat_addr;
            st_data   = bus.mon_rdata_i;
            st_flags  = 3'b010;
            skid_load = wr_ev;
        end else if (wr_ev) begin
            st_valid = 1'b1;
            st_addr  = bus.mon_addr_i;
            st_data  = bus.mon_wdata_i;
            st_flags = 3'b001;
        end
        st_drop = st_valid && full && ctrl_mode_i;
        st_we   = st_valid && !st_drop;
        if (st_drop) begin
            drop_inc = drop_inc + 2'd1;
        end
    end

    assign drop_sum = {1'b0, drop_cnt_o} + {15'd0, drop_inc};
    assign rd_phys  = head + bus.rd_idx_i;

    always_ff @(posedge clk) begin
        if (state == S_FLUSH) begin
            mem_addr[flush_idx]  <= '0;
            mem_data[flush_idx]  <= '0;
            mem_flags[flush_idx] <= 3'b000;
        end else if (st_we) begin
            mem_addr[wr_ptr]  <= st_addr;
            mem_data[wr_ptr]  <= st_data;
            mem_flags[wr_ptr] <= st_flags;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            flush_idx  <= '0;
            head       <= '0;
            wr_ptr     <= '0;
            count_o    <= '0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
            pending    <= 1'b0;
            lat_addr   <= '0;
            skid_valid <= 1'b0;
            skid_addr  <= '0;
            skid_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ctrl_flush_i) begin
                        state     <= S_FLUSH;
                        flush_idx <= '0;
                    end
                end
                S_FLUSH: begin
                    flush_idx <= flush_idx + 1'b1;
                    if (flush_idx == IDX_W'(DEPTH - 1)) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (clearing) begin
                head       <= '0;
                wr_ptr     <= '0;
                count_o    <= '0;
                overflow_o <= 1'b0;
                drop_cnt_o <= '0;
                pending    <= 1'b0;
                skid_valid <= 1'b0;
            end else begin
                if (rd_accept) begin
                    pending  <= 1'b1;
                    lat_addr <= bus.mon_addr_i;
                end else if (bus.mon_resp_i) begin
                    pending <= 1'b0;
                end
                skid_valid <= skid_load;
                if (skid_load) begin
                    skid_addr <= bus.mon_addr_i;
                    skid_data <= bus.mon_wdata_i;
                end
                // When full in wrap mode the write lands on the oldest slot, so head follows wr_ptr.
                if (st_we) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (full) begin
                        head <= head + 1'b1;
                    end else begin
                        count_o <= count_o + 1'b1;
                    end
                end
                if (full || (st_we && (count_o == FULL_CNT - 1'b1))) begin
                    overflow_o <= 1'b1;
                end
                drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
        end
    end

`ifdef MEM_TRACE_TS_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] skid_ts;
    logic [TS_W-1:0] st_ts;
    logic [TS_W-1:0] mem_ts [DEPTH];

    assign st_ts = st_flags[2] ? skid_ts : ts_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt  <= '0;
            skid_ts <= '0;
        end else begin
            ts_cnt <= clearing ? '0 : ts_cnt + 1'b1;
            if (skid_load) begin
                skid_ts <= ts_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_FLUSH) begin
            mem_ts[flush_idx] <= '0;
        end else if (st_we) begin
            mem_ts[wr_ptr] <= st_ts;
        end
    end

    assign ts_rd = mem_ts[rd_phys];
`else
    assign ts_rd = '0;
`endif

    assign busy_o       = (state == S_FLUSH);
    assign flush_done_o = (state == S_DONE);
    assign bus.rd_ack_o = !busy_o && !rst;
    assign rd_take      = bus.rd_req_i && bus.rd_ack_o;

    // Indices at or beyond the live count read back as zero rather than stale storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rd_resp_o <= 1'b0;
            bus.rd_data_o <= '0;
        end else begin
            bus.rd_resp_o <= rd_take;
            if (rd_take && ({1'b0, bus.rd_idx_i} < count_o)) begin
                case (bus.rd_field_i)
                    2'd0:    bus.rd_data_o <= 32'(mem_addr[rd_phys]);
                    2'd1:    bus.rd_data_o <= 32'(mem_data[rd_phys]);
                    2'd2:    bus.rd_data_o <= {29'd0, mem_flags[rd_phys]};
                    default: bus.rd_data_o <= 32'(ts_rd);
                endcase
            end else begin
                bus.rd_data_o <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_trace_buf.sv
// Directed bench for mem_trace_buf with a readout scoreboard; small DEPTH keeps wrap and flush runs short.
module tb_mem_trace_buf;
    localparam int DEPTH = 8;
    localparam int IDX_W = $clog2(DEPTH);

    logic        clk;
    logic        rst;
    logic        ctrl_en;
    logic        ctrl_flush;
    logic        ctrl_mode;
    logic [31:0] filt_base;
    logic [31:0] filt_mask;
    logic [IDX_W:0] count;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        flush_done;
    logic        busy;

    int          vectors;
    int          errors;
    int          edge_cnt;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    mem_trace_buf_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) bus ();

    mem_trace_buf #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .TS_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .ctrl_en_i    (ctrl_en),
        .ctrl_flush_i (ctrl_flush),
        .ctrl_mode_i  (ctrl_mode),
        .filt_base_i  (filt_base),
        .filt_mask_i  (filt_mask),
        .bus          (bus),
        .count_o      (count),
        .overflow_o   (overflow),
        .drop_cnt_o   (drop_cnt),
        .flush_done_o (flush_done),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts edges since reset release; equals the DUT timestamp until the first flush.
    always @(posedge clk) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic req, input logic we, input logic resp,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] rdata);
        bus.mon_req_i   = req;
        bus.mon_ack_i   = req;
        bus.mon_we_i    = we;
        bus.mon_addr_i  = addr;
        bus.mon_wdata_i = wdata;
        bus.mon_resp_i  = resp;
        bus.mon_rdata_i = rdata;
        tick();
        bus.mon_req_i   = 1'b0;
        bus.mon_ack_i   = 1'b0;
        bus.mon_we_i    = 1'b0;
        bus.mon_resp_i  = 1'b0;
    endtask

    task automatic read_entry(input int idx, input int field, input logic [31:0] exp, input string tag);
        int          waited;
        logic [31:0] e;
        string       t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        bus.rd_req_i   = 1'b1;
        bus.rd_idx_i   = IDX_W'(idx);
        bus.rd_field_i = 2'(field);
        tick();
        bus.rd_req_i = 1'b0;
        waited = 0;
        while (!bus.rd_resp_o && waited < 4) begin
            tick();
            waited++;
        end
        check_output({tag, "/resp"}, {31'd0, bus.rd_resp_o}, 32'd1);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (bus.rd_resp_o) check_output(t, bus.rd_data_o, e);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        ctrl_flush = 1'b0;
        bus.mon_req_i = 1'b0; bus.mon_ack_i = 1'b0; bus.mon_we_i = 1'b0;
        bus.mon_resp_i = 1'b0; bus.rd_req_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int ts_a;
        int ts_b;
        int busy_cycles;
        int n;
        vectors = 0;
        errors  = 0;
        rst = 1'b1;
        ctrl_en = 1'b0; ctrl_flush = 1'b0; ctrl_mode = 1'b0;
        filt_base = '0; filt_mask = '0;
        bus.mon_req_i = 1'b0; bus.mon_ack_i = 1'b0; bus.mon_we_i = 1'b0;
        bus.mon_addr_i = '0; bus.mon_wdata_i = '0; bus.mon_resp_i = 1'b0; bus.mon_rdata_i = '0;
        bus.rd_req_i = 1'b0; bus.rd_idx_i = '0; bus.rd_field_i = '0;
        tick();
        tick();
        check_output("rst_count", 32'(count), 32'd0);
        check_output("rst_overflow", {31'd0, overflow}, 32'd0);
        check_output("rst_drop", {16'd0, drop_cnt}, 32'd0);
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        check_output("rst_done", {31'd0, flush_done}, 32'd0);
        check_output("rst_ack", {31'd0, bus.rd_ack_o}, 32'd0);
        check_output("rst_resp", {31'd0, bus.rd_resp_o}, 32'd0);
        rst = 1'b0;
        #1;
        check_output("ack_after_rst", {31'd0, bus.rd_ack_o}, 32'd1);

        $display("[TB] two writes");
        ctrl_en = 1'b1;
        ts_a = edge_cnt;
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h100, 32'hA5, 32'h0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h104, 32'h5A, 32'h0);
        check_output("t1_count", 32'(count), 32'd2);
        read_entry(0, 0, 32'h100, "t1_addr0");
        read_entry(0, 1, 32'hA5, "t1_data0");
        read_entry(0, 2, 32'h1, "t1_flags0");
        read_entry(1, 1, 32'h5A, "t1_data1");
        read_entry(2, 0, 32'h0, "t1_beyond_count");
`ifdef MEM_TRACE_TS_EN
        read_entry(0, 3, 32'(ts_a & 16'hFFFF), "t1_ts0");
        read_entry(1, 3, 32'((ts_a + 1) & 16'hFFFF), "t1_ts1");
`else
        read_entry(0, 3, 32'h0, "t1_ts0");
`endif

        $display("[TB] monitored read");
        reset_dut();
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        ts_a = edge_cnt;
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'hDEAD);
        check_output("t2_count", 32'(count), 32'd1);
        read_entry(0, 0, 32'h200, "t2_addr");
        read_entry(0, 1, 32'hDEAD, "t2_data");
        read_entry(0, 2, 32'h2, "t2_flags");
`ifdef MEM_TRACE_TS_EN
        read_entry(0, 3, 32'(ts_a & 16'hFFFF), "t2_ts");
`endif

        $display("[TB] wrap mode");
        reset_dut();
        ctrl_mode = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 32'(i), 32'(i + 16), 32'h0);
        end
        check_output("wrap_count", 32'(count), 32'(DEPTH));
        check_output("wrap_overflow", {31'd0, overflow}, 32'd1);
        check_output("wrap_drop", {16'd0, drop_cnt}, 32'd0);
        read_entry(0, 0, 32'd3, "wrap_oldest");
        read_entry(DEPTH - 1, 0, 32'(DEPTH + 2), "wrap_newest");

        $display("[TB] stop mode");
        reset_dut();
        ctrl_mode = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 32'(i), 32'(i + 16), 32'h0);
        end
        check_output("stop_count", 32'(count), 32'(DEPTH));
        check_output("stop_overflow", {31'd0, overflow}, 32'd1);
        check_output("stop_drop", {16'd0, drop_cnt}, 32'd3);
        read_entry(0, 0, 32'd0, "stop_oldest");
        read_entry(DEPTH - 1, 0, 32'(DEPTH - 1), "stop_newest");
        ctrl_mode = 1'b0;

        $display("[TB] address filter");
        reset_dut();
        filt_base = 32'h1000;
        filt_mask = 32'hF000;
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h1004, 32'h1, 32'h0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h2004, 32'h2, 32'h0);
        check_output("filt_count", 32'(count), 32'd1);
        read_entry(0, 0, 32'h1004, "filt_addr");
        filt_base = '0;
        filt_mask = '0;

        $display("[TB] skid register");
        reset_dut();
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0);
        ts_b = edge_cnt;
        apply_stimulus(1'b1, 1'b1, 1'b1, 32'h304, 32'h11, 32'hBEEF);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h308, 32'h22, 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h30C, 32'h33, 32'h0);
        check_output("skid_count", 32'(count), 32'd3);
        check_output("skid_drop", {16'd0, drop_cnt}, 32'd1);
        read_entry(0, 1, 32'hBEEF, "skid_rd_data");
        read_entry(0, 2, 32'h2, "skid_rd_flags");
        read_entry(1, 0, 32'h304, "skid_wr_addr");
        read_entry(1, 2, 32'h5, "skid_wr_flags");
        read_entry(2, 0, 32'h30C, "skid_next_addr");
`ifdef MEM_TRACE_TS_EN
        read_entry(1, 3, 32'(ts_b & 16'hFFFF), "skid_wr_ts");
`endif

        $display("[TB] flush");
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h400, 32'h44, 32'h0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h404, 32'h55, 32'h0);
        check_output("pre_flush_count", 32'(count), 32'd5);
        ctrl_flush = 1'b1;
        tick();
        ctrl_flush = 1'b0;
        check_output("flush_busy", {31'd0, busy}, 32'd1);
        check_output("flush_ack_low", {31'd0, bus.rd_ack_o}, 32'd0);
        busy_cycles = 0;
        n = 0;
        while (busy && n < 4 * DEPTH) begin
            busy_cycles++;
            ctrl_flush = (n == 3);
            tick();
            n++;
        end
        ctrl_flush = 1'b0;
        check_output("flush_len", 32'(busy_cycles), 32'(DEPTH));
        check_output("flush_done", {31'd0, flush_done}, 32'd1);
        check_output("flush_count", 32'(count), 32'd0);
        check_output("flush_overflow", {31'd0, overflow}, 32'd0);
        check_output("flush_drop", {16'd0, drop_cnt}, 32'd0);
        tick();
        check_output("flush_done_pulse", {31'd0, flush_done}, 32'd0);
        check_output("post_flush_ack", {31'd0, bus.rd_ack_o}, 32'd1);
        read_entry(0, 0, 32'h0, "post_flush_read");

        $display("[TB] reset during flush");
        ctrl_flush = 1'b1;
        tick();
        ctrl_flush = 1'b0;
        tick();
        tick();
        check_output("mid_flush_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_output("rst_mid_busy", {31'd0, busy}, 32'd0);
        check_output("rst_mid_done", {31'd0, flush_done}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check_output("rst_mid_idle", {31'd0, busy}, 32'd0);
        check_output("rst_mid_ack", {31'd0, bus.rd_ack_o}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
